a5_stream_ctrl: RTL and testbench

Sequencing and combining stage for the A5/1 datapath. It drives the shift input, per-register clock enables and register reset of the three external LFSRs (X 19-bit, Y 22-bit, Z 23-bit). It loads a 64-bit key and a 22-bit frame number, runs the majority-clocked warm-up, then XORs the keystream with a byte stream under valid/ready handshakes. It replaces hand-sequenced bench stimulus with synthesizable control.

---
 rtl/a5_stream_ctrl_if.sv | 21 ++
 rtl/a5_stream_ctrl.sv | 168 ++++++++++++++++
 tb/tb_a5_stream_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/a5_stream_ctrl_if.sv
// rtl/a5_stream_ctrl_if.sv - byte stream handshake bundle for the A5/1 stream controller
interface a5_stream_ctrl_if #(
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/a5_stream_ctrl.sv
// rtl/a5_stream_ctrl.sv - A5/1 load/warm-up sequencer and keystream byte combiner
module a5_stream_ctrl #(
    parameter int KEY_W   = 64,
    parameter int FRAME_W = 22,
    parameter int WARMUP  = 100,
    parameter int BYTE_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [KEY_W-1:0]   key,
    input  logic [FRAME_W-1:0] frame,
    output logic               lfsr_rst_n,
    output logic               shift_bit,
    output logic [2:0]         triggers,
    input  logic               x_tap,
    input  logic               y_tap,
    input  logic               z_tap,
    input  logic               x_out,
    input  logic               y_out,
    input  logic               z_out,
    a5_stream_ctrl_if.slave    strm,
    output logic               busy,
    output logic               ks_ready
);
    localparam int MAX_A = (KEY_W > FRAME_W) ? KEY_W : FRAME_W;
    localparam int MAX_B = (WARMUP > BYTE_W) ? WARMUP : BYTE_W;
    localparam int MAX_N = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_N);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_KEY, S_FRAME, S_WARM, S_RUN, S_GEN, S_HOLD
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [KEY_W-1:0]    key_sr;
    logic [FRAME_W-1:0]  frame_sr;
    logic [BYTE_W-1:0]   data_sr;
    logic [BYTE_W-1:0]   out_data_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                maj_m;
    logic [2:0]          maj_en;
    logic                ks_bit;

    // Majority enables follow this cycle's taps so the LFSRs step on the same edge.
    assign maj_m  = (x_tap & y_tap) | (x_tap & z_tap) | (y_tap & z_tap);
    assign maj_en = {~(x_tap ^ maj_m), ~(y_tap ^ maj_m), ~(z_tap ^ maj_m)};
    assign ks_bit = x_out ^ y_out ^ z_out;

    assign strm.in_ready  = in_ready_q;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;

    always_comb begin
        triggers  = 3'b000;
        shift_bit = 1'b0;
        case (state)
            S_KEY: begin
                triggers  = 3'b111;
                shift_bit = key_sr[KEY_W-1];
            end
            S_FRAME: begin
                triggers  = 3'b111;
                shift_bit = frame_sr[FRAME_W-1];
            end
            S_WARM, S_GEN: triggers = maj_en;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            key_sr      <= '0;
            frame_sr    <= '0;
            data_sr     <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            lfsr_rst_n  <= 1'b1;
            busy        <= 1'b0;
            ks_ready    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    key_sr     <= key;
                    frame_sr   <= frame;
                    cnt        <= '0;
                    lfsr_rst_n <= 1'b0;
                    busy       <= 1'b1;
                    state      <= S_CLEAR;
                end
                S_CLEAR: begin
                    lfsr_rst_n <= 1'b1;
                    state      <= S_KEY;
                end
                S_KEY: begin
                    key_sr <= key_sr << 1;
                    if (cnt == CNT_W'(KEY_W - 1)) begin
                        cnt   <= '0;
                        state <= S_FRAME;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_FRAME: begin
                    frame_sr <= frame_sr << 1;
                    if (cnt == CNT_W'(FRAME_W - 1)) begin
                        cnt   <= '0;
                        state <= S_WARM;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WARM: begin
                    if (cnt == CNT_W'(WARMUP - 1)) begin
                        cnt        <= '0;
                        busy       <= 1'b0;
                        ks_ready   <= 1'b1;
                        in_ready_q <= 1'b1;
                        state      <= S_RUN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // A word transfer wins over stop in the same cycle.
                    if (strm.in_valid && in_ready_q) begin
                        data_sr    <= strm.in_data;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        ks_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_GEN;
                    end else if (stop) begin
                        in_ready_q <= 1'b0;
                        ks_ready   <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_GEN: begin
                    // LSB-first: each result bit enters at the top, so bit 0 ends at position 0.
                    data_sr <= {ks_bit ^ data_sr[0], data_sr[BYTE_W-1:1]};
                    if (cnt == CNT_W'(BYTE_W - 1)) begin
                        cnt         <= '0;
                        out_data_q  <= {ks_bit ^ data_sr[0], data_sr[BYTE_W-1:1]};
                        out_valid_q <= 1'b1;
                        state       <= S_HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HOLD: if (strm.out_ready) begin
                    out_valid_q <= 1'b0;
                    busy        <= 1'b0;
                    ks_ready    <= 1'b1;
                    in_ready_q  <= 1'b1;
                    state       <= S_RUN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_a5_stream_ctrl.sv
// tb/tb_a5_stream_ctrl.sv - self-checking bench for a5_stream_ctrl with behavioural A5/1 reference
module tb_a5_stream_ctrl;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, stop;
    logic [63:0] key;
    logic [21:0] frame;
    logic        lfsr_rst_n, shift_bit, busy, ks_ready;
    logic [2:0]  triggers;
    logic        x_tap, y_tap, z_tap, x_out, y_out, z_out;
    logic        use_lfsr;
    logic        fx_tap, fy_tap, fz_tap, fx_out, fy_out, fz_out;
    logic [18:0] lx = '0;
    logic [21:0] ly = '0;
    logic [22:0] lz = '0;
    int          n_assert = 0;
    int          n_fail   = 0;
    bit          ref_ks[$];

    a5_stream_ctrl_if sif();

    a5_stream_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .key(key), .frame(frame),
        .lfsr_rst_n(lfsr_rst_n), .shift_bit(shift_bit), .triggers(triggers),
        .x_tap(x_tap), .y_tap(y_tap), .z_tap(z_tap),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .strm(sif), .busy(busy), .ks_ready(ks_ready)
    );

    task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [18:0] nx1(bit [18:0] r, bit b);
        return {r[17:0], r[18] ^ r[17] ^ r[16] ^ r[13] ^ b};
    endfunction
    function automatic bit [21:0] nx2(bit [21:0] r, bit b);
        return {r[20:0], r[21] ^ r[20] ^ b};
    endfunction
    function automatic bit [22:0] nx3(bit [22:0] r, bit b);
        return {r[21:0], r[22] ^ r[21] ^ r[20] ^ r[7] ^ b};
    endfunction

    always @(posedge clk) begin
        if (!lfsr_rst_n) begin
            lx <= '0; ly <= '0; lz <= '0;
        end else begin
            if (triggers[2]) lx <= nx1(lx, shift_bit);
            if (triggers[1]) ly <= nx2(ly, shift_bit);
            if (triggers[0]) lz <= nx3(lz, shift_bit);
        end
    end

    assign x_tap = use_lfsr ? lx[8]  : fx_tap;
    assign y_tap = use_lfsr ? ly[10] : fy_tap;
    assign z_tap = use_lfsr ? lz[10] : fz_tap;
    assign x_out = use_lfsr ? lx[18] : fx_out;
    assign y_out = use_lfsr ? ly[21] : fy_out;
    assign z_out = use_lfsr ? lz[22] : fz_out;

    task automatic build_ref(input logic [63:0] k, input logic [21:0] f, input int nbits);
        bit [18:0] r1 = '0;
        bit [21:0] r2 = '0;
        bit [22:0] r3 = '0;
        int s;
        bit m;
        for (int i = 0; i < 64; i++) begin
            r1 = nx1(r1, k[63-i]); r2 = nx2(r2, k[63-i]); r3 = nx3(r3, k[63-i]);
        end
        for (int i = 0; i < 22; i++) begin
            r1 = nx1(r1, f[21-i]); r2 = nx2(r2, f[21-i]); r3 = nx3(r3, f[21-i]);
        end
        ref_ks.delete();
        for (int i = 0; i < 100 + nbits; i++) begin
            if (i >= 100) ref_ks.push_back(r1[18] ^ r2[21] ^ r3[22]);
            s = int'(r1[8]) + int'(r2[10]) + int'(r3[10]);
            m = (s >= 2);
            if (r1[8]  == m) r1 = nx1(r1, 1'b0);
            if (r2[10] == m) r2 = nx2(r2, 1'b0);
            if (r3[10] == m) r3 = nx3(r3, 1'b0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic startup(input logic [63:0] k, input logic [21:0] f);
        int low_cnt = 0;
        key = k; frame = f; start = 1'b1;
        step();
        start = 1'b0;
        key = {$urandom, $urandom}; frame = 22'($urandom);
        for (int c = 1; c <= 87; c++) begin
            if (c > 1) step();
            chk("load_busy", busy === 1'b1, busy, 1'b1);
            if (lfsr_rst_n === 1'b0) low_cnt++;
            if (c == 1) begin
                chk("clear_triggers", triggers === 3'b000, triggers, 3'b000);
            end else begin
                chk("load_triggers", triggers === 3'b111, triggers, 3'b111);
                if (c <= 65) begin
                    chk("key_shift_bit", shift_bit === k[63-(c-2)], shift_bit, k[63-(c-2)]);
                end else begin
                    chk("frame_shift_bit", shift_bit === f[21-(c-66)], shift_bit, f[21-(c-66)]);
                end
            end
        end
        chk("lfsr_rst_low_cycles", low_cnt == 1, low_cnt, 1);
    endtask

    task automatic warm();
        logic [2:0] pat_taps [3] = '{3'b100, 3'b110, 3'b000};
        logic [2:0] pat_trig [3] = '{3'b011, 3'b110, 3'b111};
        logic [2:0] exp;
        int s;
        bit m;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!use_lfsr) begin
                if (i < 3) {fx_tap, fy_tap, fz_tap} = pat_taps[i];
                else       {fx_tap, fy_tap, fz_tap} = 3'($urandom);
                #1;
            end
            s = int'(x_tap) + int'(y_tap) + int'(z_tap);
            m = (s >= 2);
            exp = {x_tap == m, y_tap == m, z_tap == m};
            if (!use_lfsr && i < 3) exp = pat_trig[i];
            chk("warm_triggers", triggers === exp, triggers, exp);
            chk("warm_shift_bit", shift_bit === 1'b0, shift_bit, 1'b0);
            chk("warm_busy", busy === 1'b1, busy, 1'b1);
        end
        step();
        chk("run_ks_ready", ks_ready === 1'b1, ks_ready, 1'b1);
        chk("run_busy", busy === 1'b0, busy, 1'b0);
        chk("run_in_ready", sif.in_ready === 1'b1, sif.in_ready, 1'b1);
        chk("run_triggers", triggers === 3'b000, triggers, 3'b000);
    endtask

    task automatic do_word(input logic [7:0] d, input logic [7:0] exp, input int stall);
        int n;
        chk("word_in_ready", sif.in_ready === 1'b1, sif.in_ready, 1'b1);
        sif.in_data = d; sif.in_valid = 1'b1;
        step();
        sif.in_valid = 1'b0; sif.in_data = 8'($urandom);
        n = 1;
        while (sif.out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("word_latency", n == 9, n, 9);
        chk("word_out_data", sif.out_data === exp, sif.out_data, exp);
        for (int s = 0; s < stall; s++) begin
            step();
            chk("hold_out_valid", sif.out_valid === 1'b1, sif.out_valid, 1'b1);
            chk("hold_out_data", sif.out_data === exp, sif.out_data, exp);
            chk("hold_in_ready", sif.in_ready === 1'b0, sif.in_ready, 1'b0);
            chk("hold_triggers", triggers === 3'b000, triggers, 3'b000);
        end
        sif.out_ready = 1'b1;
        step();
        sif.out_ready = 1'b0;
        chk("release_out_valid", sif.out_valid === 1'b0, sif.out_valid, 1'b0);
        chk("release_ks_ready", ks_ready === 1'b1, ks_ready, 1'b1);
        chk("release_in_ready", sif.in_ready === 1'b1, sif.in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d, e;
        reset = 1'b0; start = 1'b0; stop = 1'b0; key = '0; frame = '0;
        use_lfsr = 1'b0;
        {fx_tap, fy_tap, fz_tap, fx_out, fy_out, fz_out} = '0;
        sif.in_data = '0; sif.in_valid = 1'b0; sif.out_ready = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom); stop = 1'($urandom);
            key = {$urandom, $urandom}; frame = 22'($urandom);
            {fx_tap, fy_tap, fz_tap, fx_out, fy_out, fz_out} = 6'($urandom);
            sif.in_data = 8'($urandom); sif.in_valid = 1'($urandom); sif.out_ready = 1'($urandom);
            step();
            chk("rst_lfsr_rst_n", lfsr_rst_n === 1'b1, lfsr_rst_n, 1'b1);
            chk("rst_shift_bit", shift_bit === 1'b0, shift_bit, 1'b0);
            chk("rst_triggers", triggers === 3'b000, triggers, 3'b000);
            chk("rst_in_ready", sif.in_ready === 1'b0, sif.in_ready, 1'b0);
            chk("rst_out_valid", sif.out_valid === 1'b0, sif.out_valid, 1'b0);
            chk("rst_out_data", sif.out_data === 8'h00, sif.out_data, 8'h00);
            chk("rst_busy", busy === 1'b0, busy, 1'b0);
            chk("rst_ks_ready", ks_ready === 1'b0, ks_ready, 1'b0);
        end
        start = 1'b0; stop = 1'b0; sif.in_valid = 1'b0; sif.out_ready = 1'b0;
        {fx_tap, fy_tap, fz_tap, fx_out, fy_out, fz_out} = '0;
        reset = 1'b1;
        step();
        chk("start_in_reset_ignored", busy === 1'b0, busy, 1'b0);

        key = {$urandom, $urandom}; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 32; c++) step();
        chk("abort_pre_triggers", triggers === 3'b111, triggers, 3'b111);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_busy", busy === 1'b0, busy, 1'b0);
        chk("abort_triggers", triggers === 3'b000, triggers, 3'b000);
        chk("abort_lfsr_rst_n", lfsr_rst_n === 1'b1, lfsr_rst_n, 1'b1);
        chk("abort_ks_ready", ks_ready === 1'b0, ks_ready, 1'b0);
        chk("abort_shift_bit", shift_bit === 1'b0, shift_bit, 1'b0);
        step();
        chk("abort_stays_idle", busy === 1'b0, busy, 1'b0);

        use_lfsr = 1'b1;
        startup(64'h5157455241534446, 22'b1101001110000110010001);
        warm();
        build_ref(64'h5157455241534446, 22'b1101001110000110010001, 48);
        for (int w = 0; w < 6; w++) begin
            d = 8'($urandom);
            for (int j = 0; j < 8; j++) e[j] = d[j] ^ ref_ks[8*w + j];
            do_word(d, e, (w == 0) ? 20 : int'($urandom_range(0, 3)));
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_run_ignored", ks_ready === 1'b1, ks_ready, 1'b1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_ks_ready", ks_ready === 1'b0, ks_ready, 1'b0);
        chk("stop_busy", busy === 1'b0, busy, 1'b0);
        chk("stop_in_ready", sif.in_ready === 1'b0, sif.in_ready, 1'b0);

        use_lfsr = 1'b0;
        startup({$urandom, $urandom}, 22'($urandom));
        warm();
        {fx_tap, fy_tap, fz_tap, fx_out, fy_out, fz_out} = '0;
        do_word(8'h5A, 8'h5A, 0);
        fx_out = 1'b1;
        do_word(8'h5A, 8'hA5, 2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop2_ks_ready", ks_ready === 1'b0, ks_ready, 1'b0);
        chk("stop2_busy", busy === 1'b0, busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
